inst_idfr_stage: RTL and testbench

- Registered instruction-identification stage that replaces the per-opcode combinational identifiers.
- Decodes the OP_IMM and OP opcodes into the shared instruction-ID encoding for XLEN=32 or 64.
- Buffers results in a small FIFO with valid/ready handshakes on both sides.
- Flags illegal encodings and counts them. Sits between fetch and the decode/operand-read stage.

---
 rtl/inst_idfr_stage.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_inst_idfr_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_idfr_stage.sv
// -----------------------------------------------------------------------------
// inst_idfr_stage
//
// Registered instruction-identification stage between fetch and the
// decode/operand-read stage. It classifies OP_IMM and OP instructions into the
// shared instruction-ID encoding and buffers each result, together with the
// raw instruction and its PC, in a small FIFO. Both sides of the FIFO use
// valid/ready handshakes. Encodings that identify as NONE_ID are flagged as
// illegal, and a saturating counter tracks how many of them were accepted.
//
// Optional feature (compile-time macro):
//   OP_M_DECODE_EN - when defined, OP with funct7=0000001 identifies as the
//                    M-extension operations (MUL..REMU). When it is undefined,
//                    these encodings are NONE_ID and are counted as illegal.
//
// Parameters:
//   XLEN        - datapath width, 32 or 64. Selects the shift-immediate rule.
//   DEPTH       - number of FIFO entries. Must be a power of two and >= 2.
//   PC_W        - width of the carried PC.
//   CNT_W       - width of the illegal-instruction counter.
//   INST_ID_LEN - width of the shared instruction-ID encoding. Keep at 6.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_valid / in_ready - upstream handshake; in_ready is registered
//   in_instr, in_pc     - raw instruction and its PC
//   flush               - drop every buffered entry and the current input
//   out_valid/out_ready - downstream handshake on the head entry
//   out_instr_id        - instruction ID of the head entry (NONE_ID when empty)
//   out_instr, out_pc   - raw instruction and PC of the head entry (0 when empty)
//   out_illegal         - the head entry identified as NONE_ID
//   illegal_cnt         - saturating count of illegal instructions pushed
// -----------------------------------------------------------------------------
module inst_idfr_stage #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 2,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 16,
  parameter int INST_ID_LEN = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INST_ID_LEN-1:0] out_instr_id,
  output logic [31:0]            out_instr,
  output logic [PC_W-1:0]        out_pc,
  output logic                   out_illegal,
  output logic [CNT_W-1:0]       illegal_cnt
);

  // Shared instruction-ID encoding.
  localparam logic [INST_ID_LEN-1:0] NONE_ID   = 6'd0;
  localparam logic [INST_ID_LEN-1:0] ADDI_ID   = 6'd1;
  localparam logic [INST_ID_LEN-1:0] SLTI_ID   = 6'd2;
  localparam logic [INST_ID_LEN-1:0] SLTIU_ID  = 6'd3;
  localparam logic [INST_ID_LEN-1:0] XORI_ID   = 6'd4;
  localparam logic [INST_ID_LEN-1:0] ORI_ID    = 6'd5;
  localparam logic [INST_ID_LEN-1:0] ANDI_ID   = 6'd6;
  localparam logic [INST_ID_LEN-1:0] SLLI_ID   = 6'd7;
  localparam logic [INST_ID_LEN-1:0] SRLI_ID   = 6'd8;
  localparam logic [INST_ID_LEN-1:0] SRAI_ID   = 6'd9;
  localparam logic [INST_ID_LEN-1:0] ADD_ID    = 6'd10;
  localparam logic [INST_ID_LEN-1:0] SUB_ID    = 6'd11;
  localparam logic [INST_ID_LEN-1:0] SLL_ID    = 6'd12;
  localparam logic [INST_ID_LEN-1:0] SLT_ID    = 6'd13;
  localparam logic [INST_ID_LEN-1:0] SLTU_ID   = 6'd14;
  localparam logic [INST_ID_LEN-1:0] XOR_ID    = 6'd15;
  localparam logic [INST_ID_LEN-1:0] SRL_ID    = 6'd16;
  localparam logic [INST_ID_LEN-1:0] SRA_ID    = 6'd17;
  localparam logic [INST_ID_LEN-1:0] OR_ID     = 6'd18;
  localparam logic [INST_ID_LEN-1:0] AND_ID    = 6'd19;
  localparam logic [INST_ID_LEN-1:0] MUL_ID    = 6'd20;
  localparam logic [INST_ID_LEN-1:0] MULH_ID   = 6'd21;
  localparam logic [INST_ID_LEN-1:0] MULHSU_ID = 6'd22;
  localparam logic [INST_ID_LEN-1:0] MULHU_ID  = 6'd23;
  localparam logic [INST_ID_LEN-1:0] DIV_ID    = 6'd24;
  localparam logic [INST_ID_LEN-1:0] DIVU_ID   = 6'd25;
  localparam logic [INST_ID_LEN-1:0] REM_ID    = 6'd26;
  localparam logic [INST_ID_LEN-1:0] REMU_ID   = 6'd27;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Identify one instruction from its opcode, funct3 and funct7 fields.
  function automatic logic [INST_ID_LEN-1:0] decode_id(
    input logic [6:0] opcode,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    logic [INST_ID_LEN-1:0] id;
    logic                   sh_log_ok;
    logic                   sh_ari_ok;
    id = NONE_ID;
    // On RV64, funct7[0] is shamt[5], so only the upper six bits are checked.
    if (XLEN == 64) begin
      sh_log_ok = (f7[6:1] == 6'b000000);
      sh_ari_ok = (f7[6:1] == 6'b010000);
    end else begin
      sh_log_ok = (f7 == 7'b0000000);
      sh_ari_ok = (f7 == 7'b0100000);
    end
    case (opcode)
      OPC_OP_IMM: begin
        case (f3)
          3'b000:  id = ADDI_ID;
          3'b010:  id = SLTI_ID;
          3'b011:  id = SLTIU_ID;
          3'b100:  id = XORI_ID;
          3'b110:  id = ORI_ID;
          3'b111:  id = ANDI_ID;
          3'b001:  id = sh_log_ok ? SLLI_ID : NONE_ID;
          3'b101: begin
            if (sh_log_ok) begin
              id = SRLI_ID;
            end else if (sh_ari_ok) begin
              id = SRAI_ID;
            end else begin
              id = NONE_ID;
            end
          end
          default: id = NONE_ID;
        endcase
      end
      OPC_OP: begin
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  id = ADD_ID;
              3'b001:  id = SLL_ID;
              3'b010:  id = SLT_ID;
              3'b011:  id = SLTU_ID;
              3'b100:  id = XOR_ID;
              3'b101:  id = SRL_ID;
              3'b110:  id = OR_ID;
              3'b111:  id = AND_ID;
              default: id = NONE_ID;
            endcase
          end
          7'b0100000: begin
            case (f3)
              3'b000:  id = SUB_ID;
              3'b101:  id = SRA_ID;
              default: id = NONE_ID;
            endcase
          end
`ifdef OP_M_DECODE_EN
          7'b0000001: begin
            case (f3)
              3'b000:  id = MUL_ID;
              3'b001:  id = MULH_ID;
              3'b010:  id = MULHSU_ID;
              3'b011:  id = MULHU_ID;
              3'b100:  id = DIV_ID;
              3'b101:  id = DIVU_ID;
              3'b110:  id = REM_ID;
              3'b111:  id = REMU_ID;
              default: id = NONE_ID;
            endcase
          end
`else
          7'b0000001: id = NONE_ID;
`endif
          default: id = NONE_ID;
        endcase
      end
      default: id = NONE_ID;
    endcase
    return id;
  endfunction

  logic [INST_ID_LEN-1:0] id_mem_r    [DEPTH];
  logic [31:0]            instr_mem_r [DEPTH];
  logic [PC_W-1:0]        pc_mem_r    [DEPTH];

  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic [CNT_W-1:0]       illegal_cnt_r;

  logic                   push_s;
  logic                   pop_s;
  logic [INST_ID_LEN-1:0] dec_id_s;
  logic                   dec_illegal_s;
  logic [CW-1:0]          count_nxt_s;
  logic [INST_ID_LEN-1:0] head_id_s;

  // Handshakes and the identification of the incoming instruction.
  always_comb begin
    push_s        = in_valid & in_ready_r & ~flush;
    pop_s         = out_valid_r & out_ready & ~flush;
    dec_id_s      = decode_id(in_instr[6:0], in_instr[14:12], in_instr[31:25]);
    dec_illegal_s = (dec_id_s == NONE_ID);
  end

  // Next occupancy. A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage. It is not reset because out_* is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      id_mem_r[wr_ptr_r]    <= dec_id_s;
      instr_mem_r[wr_ptr_r] <= in_instr;
      pc_mem_r[wr_ptr_r]    <= in_pc;
    end
  end

  // Pointers, occupancy, registered handshake flags and the illegal counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      illegal_cnt_r <= '0;
    end else if (flush) begin
      // Flush empties the FIFO but keeps the illegal-instruction history.
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s < DEPTH_C);
      out_valid_r <= (count_nxt_s != '0);
      if (push_s && dec_illegal_s && (illegal_cnt_r != CNT_MAX)) begin
        illegal_cnt_r <= illegal_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  // Head-entry view. Outputs are forced to NONE_ID/0 while empty so unreset
  // storage never leaks X.
  always_comb begin
    if (out_valid_r) begin
      head_id_s    = id_mem_r[rd_ptr_r];
      out_instr    = instr_mem_r[rd_ptr_r];
      out_pc       = pc_mem_r[rd_ptr_r];
      out_illegal  = (id_mem_r[rd_ptr_r] == NONE_ID);
    end else begin
      head_id_s    = NONE_ID;
      out_instr    = 32'h0000_0000;
      out_pc       = '0;
      out_illegal  = 1'b0;
    end
  end

  assign out_instr_id = head_id_s;
  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign illegal_cnt  = illegal_cnt_r;

endmodule

// File: tb/tb_inst_idfr_stage.sv
// -----------------------------------------------------------------------------
// tb_inst_idfr_stage
//
// Directed, self-checking bench for inst_idfr_stage. It covers the following:
// reset state, single-entry latency, decode of several instruction classes,
// full-FIFO back-pressure, sustained throughput with wrap, flush, the optional
// M decode, illegal-counter saturation, and a mid-stream reset.
// -----------------------------------------------------------------------------
module tb_inst_idfr_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int IDL   = 6;

  localparam logic [IDL-1:0] NONE_ID = 6'd0;
  localparam logic [IDL-1:0] ADDI_ID = 6'd1;
  localparam logic [IDL-1:0] SLLI_ID = 6'd7;
  localparam logic [IDL-1:0] SRAI_ID = 6'd9;
  localparam logic [IDL-1:0] ADD_ID  = 6'd10;
  localparam logic [IDL-1:0] SUB_ID  = 6'd11;
  localparam logic [IDL-1:0] SLL_ID  = 6'd12;
  localparam logic [IDL-1:0] SLTU_ID = 6'd14;
  localparam logic [IDL-1:0] XOR_ID  = 6'd15;
  localparam logic [IDL-1:0] SRL_ID  = 6'd16;
  localparam logic [IDL-1:0] OR_ID   = 6'd18;
  localparam logic [IDL-1:0] AND_ID  = 6'd19;
  localparam logic [IDL-1:0] MUL_ID  = 6'd20;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [IDL-1:0]   out_instr_id;
  logic [31:0]      out_instr;
  logic [PC_W-1:0]  out_pc;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [CNT_W-1:0] exp_cnt;

  inst_idfr_stage #(
    .XLEN(XLEN), .DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W), .INST_ID_LEN(IDL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr_id(out_instr_id),
    .out_instr(out_instr), .out_pc(out_pc), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream table for the throughput test.
  logic [31:0]    s_instr [8];
  logic [IDL-1:0] s_id    [8];

  // Safety net against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [IDL-1:0] exp_id;
    int sent;
    int received;
    int nq;
    logic do_push;
    logic do_pop;

    s_instr = '{32'h002081B3, 32'h0020C1B3, 32'h0020E1B3, 32'h0020F1B3,
                32'h0020B1B3, 32'h00500093, 32'h002091B3, 32'h0020D1B3};
    s_id    = '{ADD_ID, XOR_ID, OR_ID, AND_ID, SLTU_ID, ADDI_ID, SLL_ID, SRL_ID};

    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    exp_cnt = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_cnt", 64'(illegal_cnt), 64'd0);
    check_val("rst_id_none", 64'(out_instr_id), 64'(NONE_ID));
    check_val("rst_instr_zero", 64'(out_instr), 64'd0);

    // ADDI into an empty FIFO is visible on the next cycle.
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0000_0100;
    tick();
    in_valid = 1'b0;
    check_val("addi_valid", 64'(out_valid), 64'd1);
    check_val("addi_id", 64'(out_instr_id), 64'(ADDI_ID));
    check_val("addi_illegal", 64'(out_illegal), 64'd0);
    check_val("addi_pc", 64'(out_pc), 64'h100);
    check_val("addi_instr", 64'(out_instr), 64'h00500093);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("addi_drained", 64'(out_valid), 64'd0);

    // SRAI followed by SUB, kept in order.
    in_valid = 1'b1; in_instr = 32'h40315093; in_pc = 32'h0000_0200;
    tick();
    in_instr = 32'h402081B3; in_pc = 32'h0000_0204;
    tick();
    in_valid = 1'b0;
    check_val("full_in_ready", 64'(in_ready), 64'd0);
    check_val("srai_id", 64'(out_instr_id), 64'(SRAI_ID));
    out_ready = 1'b1;
    tick();
    check_val("sub_id", 64'(out_instr_id), 64'(SUB_ID));
    check_val("sub_pc", 64'(out_pc), 64'h204);
    tick();
    out_ready = 1'b0;
    check_val("srai_sub_drained", 64'(out_valid), 64'd0);

    // Shift immediate with instr[25]=1: legal only on RV64.
    exp_id = (XLEN == 64) ? SLLI_ID : NONE_ID;
    if (exp_id == NONE_ID) exp_cnt = exp_cnt + 4'd1;
    in_valid = 1'b1; in_instr = 32'h02011093; in_pc = 32'h0000_0300;
    tick();
    in_valid = 1'b0;
    check_val("slli_sh32_id", 64'(out_instr_id), 64'(exp_id));
    check_val("slli_sh32_illegal", 64'(out_illegal), 64'(exp_id == NONE_ID));
    check_val("slli_sh32_cnt", 64'(illegal_cnt), 64'(exp_cnt));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Three pushes against DEPTH=2 with out_ready low: the third one is held.
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h0000_0400;
    tick();
    in_instr = 32'h0020C1B3; in_pc = 32'h0000_0404;
    tick();
    in_instr = 32'h0020E1B3; in_pc = 32'h0000_0408;
    tick();
    check_val("hold_in_ready", 64'(in_ready), 64'd0);
    check_val("hold_head", 64'(out_instr_id), 64'(ADD_ID));
    out_ready = 1'b1;
    tick();
    check_val("hold_head2", 64'(out_instr_id), 64'(XOR_ID));
    check_val("hold_ready_back", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check_val("hold_head3", 64'(out_instr_id), 64'(OR_ID));
    check_val("hold_pc3", 64'(out_pc), 64'h408);
    tick();
    out_ready = 1'b0;
    check_val("hold_drained", 64'(out_valid), 64'd0);

    // Sustained stream from a full FIFO, checked against an occupancy model.
    in_valid = 1'b1; in_instr = s_instr[0]; in_pc = 32'd0;
    tick();
    in_instr = s_instr[1]; in_pc = 32'd4;
    tick();
    sent = 2; received = 0; nq = 2;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && received < 8; cyc++) begin
      in_valid = (sent < 8);
      in_instr = (sent < 8) ? s_instr[sent] : 32'h0;
      in_pc    = 32'(sent * 4);
      check_val("stream_in_ready", 64'(in_ready), 64'(nq < DEPTH));
      check_val("stream_out_valid", 64'(out_valid), 64'(nq != 0));
      if (nq != 0) begin
        check_val("stream_instr", 64'(out_instr), 64'(s_instr[received]));
        check_val("stream_id", 64'(out_instr_id), 64'(s_id[received]));
        check_val("stream_pc", 64'(out_pc), 64'(received * 4));
      end
      do_push = in_valid && (nq < DEPTH);
      do_pop  = (nq != 0);
      tick();
      if (do_pop) begin received++; nq--; end
      if (do_push) begin sent++; nq++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_val("stream_all_received", 64'(received), 64'd8);
    check_val("stream_empty", 64'(out_valid), 64'd0);

    // Flush with two entries buffered and a concurrent illegal input.
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h0000_0500;
    tick();
    in_instr = 32'h402081B3; in_pc = 32'h0000_0504;
    tick();
    check_val("pre_flush_full", 64'(in_ready), 64'd0);
    flush = 1'b1; out_ready = 1'b1; in_instr = 32'hFFFF_FFFF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_out_valid", 64'(out_valid), 64'd0);
    check_val("flush_in_ready", 64'(in_ready), 64'd1);
    check_val("flush_cnt", 64'(illegal_cnt), 64'(exp_cnt));
    tick();
    check_val("flush_stays_empty", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0000_0600;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check_val("post_flush_pc", 64'(out_pc), 64'h600);
    check_val("post_flush_id", 64'(out_instr_id), 64'(ADDI_ID));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // MUL: decoded only with the optional M feature.
`ifdef OP_M_DECODE_EN
    exp_id = MUL_ID;
`else
    exp_id = NONE_ID;
`endif
    if (exp_id == NONE_ID) exp_cnt = exp_cnt + 4'd1;
    in_valid = 1'b1; in_instr = 32'h022081B3; in_pc = 32'h0000_0700;
    tick();
    in_valid = 1'b0;
    check_val("mul_id", 64'(out_instr_id), 64'(exp_id));
    check_val("mul_cnt", 64'(illegal_cnt), 64'(exp_cnt));
    out_ready = 1'b1;
    tick();

    // Push 2^CNT_W+1 illegal instructions; the counter saturates at all-ones.
    in_valid = 1'b1; in_instr = 32'hFFFF_FFFF;
    for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
      tick();
      if (exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 4'd1;
      check_val("cnt_sat", 64'(illegal_cnt), 64'(exp_cnt));
    end
    in_valid = 1'b0;
    check_val("cnt_sat_final", 64'(illegal_cnt), 64'(CNT_MAX));
    check_val("sat_head_illegal", 64'(out_illegal), 64'd1);
    tick();
    tick();
    out_ready = 1'b0;

    // Reset in the middle of buffered traffic clears everything.
    in_valid = 1'b1; in_instr = 32'h002081B3;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_val("mid_rst_cnt", 64'(illegal_cnt), 64'd0);
    check_val("mid_rst_id", 64'(out_instr_id), 64'(NONE_ID));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
